jtcontra_gfx_rommux: RTL
========================

Name: jtcontra_gfx_rommux

Overview:
- Parametrised N-client arbiter for a single graphics SDRAM slot.
- Successor to the fixed two-client (scroll/object) local mux inside the 007121 graphics block.
- Adds: N clients, round-robin or fixed priority, per-client data latches, zero-fill for disabled clients, and re-request on address change.
- Sits between the tilemap/object fetchers and the SDRAM controller port.

Parameters:
- CLIENTS, 4, number of requesters (2..8).
- AW, 18, ROM address width.
- DW, 16, ROM data width.
- RR, 1, 1 = round-robin grant; 0 = fixed priority, lowest index wins.
- SW, $clog2(CLIENTS), width of rom_sel (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cli_cs  in  CLIENTS  per-client request level.
- cli_addr  in  CLIENTS*AW  per-client address; client i uses bits [i*AW +: AW].
- cli_en  in  CLIENTS  per-client enable; 0 means answer with zeros (test layer gating).
- cli_ok  out  CLIENTS  per-client data-valid.
- cli_data  out  CLIENTS*DW  per-client latched data.
- rom_cs  out  1  SDRAM request.
- rom_addr  out  AW  SDRAM address.
- rom_sel  out  SW  index of the granted client (drives the ROM-region select, cf. obj_sel).
- rom_data  in  DW  SDRAM data.
- rom_ok  in  1  SDRAM data valid.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - rom_cs=0, rom_addr=0, rom_sel=0.
  - cli_ok=0, cli_data=0, pending=0.
  - state=IDLE, rr pointer=CLIENTS-1, so client 0 wins first.
  - Reset mid-transaction abandons it; a later rom_ok is ignored because state is IDLE.
- Request capture, every cycle, per client i:
  - New request when cli_cs[i] rises, or when cli_cs[i]=1 and cli_addr[i] differs from its registered copy.
  - On a new request: pending[i]<=1 and cli_ok[i]<=0 at the same edge.
  - cli_cs[i] falling does not clear pending; an already-issued transaction still completes.
- Disabled client (pending[i] & ~cli_en[i]):
  - Next edge: cli_data[i]<=0, cli_ok[i]<=1, pending[i]<=0.
  - Never reaches SDRAM.
  - Works in any state.
- FSM states: IDLE, WAIT1, WAIT.
- IDLE:
  - If any pending&cli_en is set, pick grant g:
    - RR=1: first index after the rr pointer, wrapping modulo CLIENTS.
    - RR=0: lowest index.
  - Then: rom_cs<=1, rom_addr<=cli_addr[g], rom_sel<=g, pending[g]<=0, rr pointer<=g, state<=WAIT1.
  - Otherwise rom_cs<=0.
- WAIT1: ignore rom_ok (guard against a stale ok from the previous slot); state<=WAIT.
- WAIT, on rom_ok:
  - rom_cs<=0, state<=IDLE.
  - If no new request for g arrived since grant: cli_data[g]<=rom_data, cli_ok[g]<=1.
  - Otherwise discard the data; g stays pending and is re-arbitrated.
- Minimum latency: cs rises at edge t, then pending at t, rom_cs high after t+1, earliest accepted rom_ok at t+3, cli_ok high after t+3.
- Back-to-back: one IDLE cycle (rom_cs=0) is always inserted between transactions.
- Simultaneous events:
  - A new request and a disabled-zero completion for the same client in one cycle: the new request wins (ok=0, pending=1).
  - cli_en dropping while granted: the transaction completes with real data.
- Starvation: with RR=1 every pending enabled client is served within CLIENTS transactions.

Decomposition:
- Shared package jtcontra_gfx_pkg holds:
  - FSM state encoding (IDLE/WAIT1/WAIT).
  - The client-index constants used by jtcontra_gfx (CLI_SCR=0, CLI_OBJ=1).
- One sub-module: jtcontra_rr_pick, a combinational rotating priority encoder taking (req, last, RR) and returning (grant, valid).
- The FSM, latches and edge detect stay in the top module.

Test Plan:
- Single request: client 1 cs rises with addr 0x12345, rom_ok 4 cycles after rom_cs with data 0xBEEF -> rom_sel=1, rom_addr=0x12345, cli_ok[1]=1, cli_data[1]=0xBEEF, others unchanged.
- Round-robin: clients 0, 2 and 3 request at the same edge, RR=1 -> grants in order 0, 2, 3 with one idle cycle between each; with RR=0 and 0 re-requesting each time -> 0, 0, ... then 2.
- Disabled client: cli_en[2]=0, cs rises -> cli_ok[2]=1 and cli_data[2]=0 two edges later, rom_cs never asserted.
- Stale-ok guard: rom_ok held high continuously -> data is accepted only in WAIT, never in the WAIT1 cycle after grant.
- Address change in flight: client 0 granted at 0x100, addr changes to 0x200 before rom_ok -> first data discarded, cli_ok[0] stays 0, second request at 0x200 delivers data.
- Reset mid-WAIT: rst pulse, then a late rom_ok -> all outputs remain at reset values, no ok set.

Source files
------------

// File: rtl/jtcontra_gfx_pkg.sv
// Shared definitions for the jtcontra graphics ROM path: arbiter FSM
// encoding and the fixed client slots used by the 007121 graphics block.
package jtcontra_gfx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_WAIT  = 2'd2
    } rom_state_t;

    localparam int CLI_SCR = 0;
    localparam int CLI_OBJ = 1;

endpackage

// File: rtl/jtcontra_rr_pick.sv
// Rotating priority encoder: picks the first requester after 'last'
// (round-robin) or the lowest requester (fixed priority).
module jtcontra_rr_pick
    import jtcontra_gfx_pkg::*;
#(
    parameter int N  = 4,
    parameter int RR = 1,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last,
    output logic [SW-1:0] grant,
    output logic          valid
);

    // Scan from the farthest candidate to the nearest so the nearest hit is
    // the one left standing, which avoids needing a loop break.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (RR != 0) begin
                idx = (int'(last) + k) % N;
            end else begin
                idx = k - 1;
            end
            if (req[idx]) begin
                grant = SW'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtcontra_gfx_rommux.sv
// N-client arbiter for one graphics SDRAM slot, with per-client data
// latches, zero-fill for disabled clients and re-request on address change.
module jtcontra_gfx_rommux
    import jtcontra_gfx_pkg::*;
#(
    parameter int CLIENTS = 4,
    parameter int AW      = 18,
    parameter int DW      = 16,
    parameter int RR      = 1,
    parameter int SW      = $clog2(CLIENTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CLIENTS-1:0]      cli_cs,
    input  logic [CLIENTS*AW-1:0]   cli_addr,
    input  logic [CLIENTS-1:0]      cli_en,
    output logic [CLIENTS-1:0]      cli_ok,
    output logic [CLIENTS*DW-1:0]   cli_data,
    output logic                    rom_cs,
    output logic [AW-1:0]           rom_addr,
    output logic [SW-1:0]           rom_sel,
    input  logic [DW-1:0]           rom_data,
    input  logic                    rom_ok
);

    rom_state_t          state;
    rom_state_t          state_nxt;
    logic [CLIENTS-1:0]  cs_prev;
    logic [CLIENTS*AW-1:0] addr_prev;
    logic [CLIENTS-1:0]  pending;
    logic [CLIENTS-1:0]  new_req;
    logic [CLIENTS-1:0]  req_en;
    logic [SW-1:0]       rr_last;
    logic [SW-1:0]       pick;
    logic                pick_valid;
    logic                stale;
    logic                do_grant;
    logic                do_done;
    logic                in_flight;

    always_comb begin
        new_req = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            new_req[i] = cli_cs[i] &
                         (~cs_prev[i] | (cli_addr[i*AW +: AW] != addr_prev[i*AW +: AW]));
        end
    end

    assign req_en = pending & cli_en;

    jtcontra_rr_pick #(
        .N  (CLIENTS),
        .RR (RR),
        .SW (SW)
    ) u_pick (
        .req   (req_en),
        .last  (rr_last),
        .grant (pick),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (pick_valid) state_nxt = ST_WAIT1;
            ST_WAIT1: state_nxt = ST_WAIT;
            ST_WAIT:  if (rom_ok) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // rom_ok is deliberately not looked at in WAIT1: it may belong to the
    // previous slot owner.
    always_comb begin
        do_grant  = 1'b0;
        do_done   = 1'b0;
        in_flight = 1'b0;
        unique case (state)
            ST_IDLE:  do_grant = pick_valid;
            ST_WAIT1: in_flight = 1'b1;
            ST_WAIT: begin
                in_flight = 1'b1;
                do_done   = rom_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_cs    <= 1'b0;
            rom_addr  <= '0;
            rom_sel   <= '0;
            rr_last   <= SW'(CLIENTS - 1);
            stale     <= 1'b0;
            cs_prev   <= '0;
            addr_prev <= '0;
        end else begin
            cs_prev   <= cli_cs;
            addr_prev <= cli_addr;
            if (do_grant) begin
                rom_cs   <= 1'b1;
                rom_addr <= cli_addr[int'(pick)*AW +: AW];
                rom_sel  <= pick;
                rr_last  <= pick;
                stale    <= 1'b0;
            end else if (do_done || state == ST_IDLE) begin
                rom_cs <= 1'b0;
            end
            if (in_flight && new_req[rom_sel]) begin
                stale <= 1'b1;
            end
        end
    end

    // Later assignments override earlier ones: a fresh request always wins
    // over a zero-fill or SDRAM completion landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            cli_ok   <= '0;
            cli_data <= '0;
        end else begin
            for (int i = 0; i < CLIENTS; i++) begin
                if (do_done && rom_sel == SW'(i) && !stale && !new_req[i]) begin
                    cli_data[i*DW +: DW] <= rom_data;
                    cli_ok[i]            <= 1'b1;
                end
                if (pending[i] && !cli_en[i]) begin
                    cli_data[i*DW +: DW] <= '0;
                    cli_ok[i]            <= 1'b1;
                    pending[i]           <= 1'b0;
                end
                if (do_grant && pick == SW'(i)) begin
                    pending[i] <= 1'b0;
                end
                if (new_req[i]) begin
                    pending[i] <= 1'b1;
                    cli_ok[i]  <= 1'b0;
                end
            end
        end
    end

endmodule
